// File: rtl/gpio_ip_if.sv
// rtl/gpio_ip_if.sv - register bus between the system decoder and gpio_ip
interface gpio_ip_if;
  logic        sel;
  logic        write_en;
  logic        read_en;
  logic [1:0]  offset;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output sel,
    output write_en,
    output read_en,
    output offset,
    output wdata,
    input  rdata
  );

  modport slave (
    input  sel,
    input  write_en,
    input  read_en,
    input  offset,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/gpio_ip.sv
// rtl/gpio_ip.sv - memory-mapped GPIO block with per-pin direction control
module gpio_ip #(
  parameter int GPIO_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  gpio_ip_if.slave              bus,
  inout  wire  [GPIO_WIDTH-1:0] gpio_pins
);

  localparam logic [1:0] OFF_DATA = 2'd0;
  localparam logic [1:0] OFF_DIR  = 2'd1;
  localparam logic [1:0] OFF_READ = 2'd2;

  logic [GPIO_WIDTH-1:0] data_q;
  logic [GPIO_WIDTH-1:0] dir_q;
  logic [GPIO_WIDTH-1:0] pin_state;
  logic [31:0]           rd_val;
  logic                  wr_fire;
  logic                  unused_wdata;

  assign wr_fire      = bus.sel && bus.write_en;
  assign unused_wdata = ^bus.wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      dir_q  <= '0;
    end else if (wr_fire) begin
      // READ and the reserved offset silently drop writes
      case (bus.offset)
        OFF_DATA: data_q <= bus.wdata[GPIO_WIDTH-1:0];
        OFF_DIR:  dir_q  <= bus.wdata[GPIO_WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
    assign gpio_pins[i] = dir_q[i] ? data_q[i] : 1'bz;
  end

  // Unsynchronised: callers sampling asynchronous sources own metastability
  assign pin_state = gpio_pins;

  always_comb begin
    rd_val = 32'h0;
    case (bus.offset)
      OFF_DATA: rd_val[GPIO_WIDTH-1:0] = data_q;
      OFF_DIR:  rd_val[GPIO_WIDTH-1:0] = dir_q;
      OFF_READ: rd_val[GPIO_WIDTH-1:0] = pin_state;
      default:  rd_val = 32'h0;
    endcase
  end

  assign bus.rdata = (bus.sel && bus.read_en) ? rd_val : 32'h0;

endmodule

// File: tb/tb_gpio_ip.sv
// tb/tb_gpio_ip.sv - directed self-checking bench for gpio_ip
module tb_gpio_ip;
  logic       clk;
  logic       rst;
  logic [4:0] ext_en;
  logic [4:0] ext_val;
  wire  [4:0] gpio_pins;
  int         n_checks;
  int         n_fail;

  gpio_ip_if bus ();

  gpio_ip #(.GPIO_WIDTH(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .gpio_pins (gpio_pins)
  );

  for (genvar i = 0; i < 5; i++) begin : g_ext
    assign gpio_pins[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.sel      = 1'b0;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    bus.offset   = 2'd0;
    bus.wdata    = 32'h0;
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] val);
    @(negedge clk);
    bus.sel      = 1'b1;
    bus.write_en = 1'b1;
    bus.offset   = off;
    bus.wdata    = val;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] off, output logic [31:0] val);
    @(negedge clk);
    bus.sel     = 1'b1;
    bus.read_en = 1'b1;
    bus.offset  = off;
    #1;
    val = bus.rdata;
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected %h", v, 32'h0); end
    bus_read(2'd1, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL reset_dir: got %h expected %h", v, 32'h0); end
    @(negedge clk);
    bus.sel = 1'b1; bus.offset = 2'd1; #1;
    n_checks++;
    if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_idle: got %h expected %h", bus.rdata, 32'h0); end
    bus_idle();
    ext_en = 5'h1F; ext_val = 5'b01010;
    bus_read(2'd2, v);
    n_checks++;
    if (v !== 32'h0A) begin n_fail++; $display("FAIL reset_pins_released: got %h expected %h", v, 32'h0A); end
    ext_en = 5'h00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_output_path();
    logic [31:0] v;
    bus_write(2'd1, 32'h1F);
    bus_write(2'd0, 32'h15);
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h15) begin n_fail++; $display("FAIL out_data: got %h expected %h", v, 32'h15); end
    bus_read(2'd1, v);
    n_checks++;
    if (v !== 32'h1F) begin n_fail++; $display("FAIL out_dir: got %h expected %h", v, 32'h1F); end
    n_checks++;
    if (gpio_pins !== 5'b10101) begin n_fail++; $display("FAIL out_pins: got %b expected %b", gpio_pins, 5'b10101); end
    bus_read(2'd2, v);
    n_checks++;
    if (v !== 32'h15) begin n_fail++; $display("FAIL out_read: got %h expected %h", v, 32'h15); end
  endtask

  task automatic test_input_path();
    logic [31:0] v;
    bus_write(2'd1, 32'h00);
    ext_en = 5'h1F; ext_val = 5'b11010;
    #1;
    n_checks++;
    if (gpio_pins !== 5'b11010) begin n_fail++; $display("FAIL in_pins: got %b expected %b", gpio_pins, 5'b11010); end
    bus_read(2'd2, v);
    n_checks++;
    if (v !== 32'h1A) begin n_fail++; $display("FAIL in_read: got %h expected %h", v, 32'h1A); end
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h15) begin n_fail++; $display("FAIL in_data_kept: got %h expected %h", v, 32'h15); end
    ext_en = 5'h00;
  endtask

  task automatic test_mixed();
    logic [31:0] v;
    bus_write(2'd1, 32'h03);
    bus_write(2'd0, 32'h1F);
    ext_en = 5'b11100; ext_val = 5'b10100;
    #1;
    n_checks++;
    if (gpio_pins !== 5'b10111) begin n_fail++; $display("FAIL mixed_pins: got %b expected %b", gpio_pins, 5'b10111); end
    bus_read(2'd2, v);
    n_checks++;
    if (v !== 32'h17) begin n_fail++; $display("FAIL mixed_read: got %h expected %h", v, 32'h17); end
    ext_en = 5'h00;
  endtask

  task automatic test_qualification();
    logic [31:0] v;
    @(negedge clk);
    bus.write_en = 1'b1; bus.offset = 2'd0; bus.wdata = 32'h0A;
    @(negedge clk);
    bus_idle();
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h1F) begin n_fail++; $display("FAIL qual_nosel: got %h expected %h", v, 32'h1F); end
    bus_write(2'd2, 32'h00);
    bus_write(2'd3, 32'h00);
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h1F) begin n_fail++; $display("FAIL qual_ro_data: got %h expected %h", v, 32'h1F); end
    bus_read(2'd1, v);
    n_checks++;
    if (v !== 32'h03) begin n_fail++; $display("FAIL qual_ro_dir: got %h expected %h", v, 32'h03); end
    bus_read(2'd3, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL qual_rsvd_read: got %h expected %h", v, 32'h0); end
    @(negedge clk);
    bus.sel = 1'b1; bus.offset = 2'd0; #1;
    n_checks++;
    if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL qual_no_read_en: got %h expected %h", bus.rdata, 32'h0); end
    bus_idle();
    bus_write(2'd0, 32'hFFFFFFE0);
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL qual_wdata_high: got %h expected %h", v, 32'h0); end
  endtask

  task automatic test_simultaneous_rw();
    @(negedge clk);
    bus.sel = 1'b1; bus.write_en = 1'b1; bus.read_en = 1'b1;
    bus.offset = 2'd0; bus.wdata = 32'h0C;
    #1;
    n_checks++;
    if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rw_pre_edge: got %h expected %h", bus.rdata, 32'h0); end
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    #1;
    n_checks++;
    if (bus.rdata !== 32'h0C) begin n_fail++; $display("FAIL rw_post_edge: got %h expected %h", bus.rdata, 32'h0C); end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    @(negedge clk);
    bus.sel = 1'b1; bus.write_en = 1'b1; bus.offset = 2'd1; bus.wdata = 32'h1F;
    @(negedge clk);
    bus.offset = 2'd0; bus.wdata = 32'h09;
    @(negedge clk);
    bus_idle();
    bus_read(2'd1, v);
    n_checks++;
    if (v !== 32'h1F) begin n_fail++; $display("FAIL b2b_dir: got %h expected %h", v, 32'h1F); end
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h09) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", v, 32'h09); end
    n_checks++;
    if (gpio_pins !== 5'b01001) begin n_fail++; $display("FAIL b2b_pins: got %b expected %b", gpio_pins, 5'b01001); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    bus_write(2'd1, 32'h1F);
    bus_write(2'd0, 32'h15);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    bus.sel = 1'b1; bus.read_en = 1'b1; bus.offset = 2'd1;
    #1;
    n_checks++;
    if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL arst_dir_immediate: got %h expected %h", bus.rdata, 32'h0); end
    bus.read_en = 1'b0;
    bus.write_en = 1'b1; bus.offset = 2'd0; bus.wdata = 32'h1F;
    @(negedge clk);
    bus_idle();
    rst = 1'b1;
    bus_read(2'd0, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL arst_data: got %h expected %h", v, 32'h0); end
    bus_read(2'd1, v);
    n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL arst_dir: got %h expected %h", v, 32'h0); end
    ext_en = 5'h1F; ext_val = 5'b01011;
    bus_read(2'd2, v);
    n_checks++;
    if (v !== 32'h0B) begin n_fail++; $display("FAIL arst_pins_released: got %h expected %h", v, 32'h0B); end
    ext_en = 5'h00;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ext_en   = 5'h00;
    ext_val  = 5'h00;
    rst      = 1'b0;
    bus_idle();
    test_reset();
    test_output_path();
    test_input_path();
    test_mixed();
    test_qualification();
    test_simultaneous_rw();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
